// File: rtl/inst_queue.sv
// inst_queue: DEPTH-entry fetch->decode FIFO of {pc, inst}; 1-cycle latency, 0 with INST_QUEUE_BYPASS_EN.
// Backpressure: stall_if = full from registered pointers; head held at id_* while stall_id.
`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

module inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             if_valid,
  input  logic [`ADDR_BUS] if_pc,
  input  logic [`DATA_BUS] if_inst,
  output logic             stall_if,
  input  logic             stall_id,
  output logic             id_valid,
  output logic [`ADDR_BUS] id_pc,
  output logic [`DATA_BUS] id_inst
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;

  typedef struct packed {
    logic [`ADDR_BUS] pc;
    logic [`DATA_BUS] inst;
  } entry_t;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  entry_t        head;

  logic empty;
  logic full;
  logic head_vld;
  logic push;
  logic pop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                    (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
  assign stall_if = full;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];
  assign head_vld = !empty && !flush;
  assign pop      = head_vld && !stall_id;

`ifdef INST_QUEUE_BYPASS_EN
  logic bypass;
  assign bypass = empty && if_valid && !flush;
  // A bypassed instruction that decode takes right away never occupies an entry.
  assign push   = if_valid && !full && !flush && !(bypass && !stall_id);
`else
  assign push   = if_valid && !full && !flush;
`endif

  always_comb begin
    id_valid = 1'b0;
    id_pc    = '0;
    id_inst  = '0;
    if (head_vld) begin
      id_valid = 1'b1;
      id_pc    = head.pc;
      id_inst  = head.inst;
    end
`ifdef INST_QUEUE_BYPASS_EN
    else if (bypass) begin
      id_valid = 1'b1;
      id_pc    = if_pc;
      id_inst  = if_inst;
    end
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = '{pc: if_pc, inst: if_inst};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload storage carries no reset; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue (DEPTH=4); covers the default build and INST_QUEUE_BYPASS_EN.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        stall_if;
  logic        stall_id;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int checks = 0;
  int errors = 0;

  inst_queue #(.DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst),
    .stall_if (stall_if),
    .stall_id (stall_id),
    .id_valid (id_valid),
    .id_pc    (id_pc),
    .id_inst  (id_inst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 2ns after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = inst;
    tick();
    if_valid = 1'b0;
  endtask

  logic [31:0] exp_pc [5];
  logic        accepted;

  initial begin
    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_pc = '0; if_inst = '0; stall_id = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_inst", id_inst, 32'd0);
    chk("rst_stall_if", {31'd0, stall_if}, 32'd0);

`ifndef INST_QUEUE_BYPASS_EN
    // Single instruction: visible one cycle after push, gone the cycle after.
    if_valid = 1'b1; if_pc = 32'h8000_0000; if_inst = 32'h0000_0013;
    #1;
    chk("lat_same_cycle_invalid", {31'd0, id_valid}, 32'd0);
    tick();
    if_valid = 1'b0;
    #1;
    chk("lat_id_valid", {31'd0, id_valid}, 32'd1);
    chk("lat_id_pc", id_pc, 32'h8000_0000);
    chk("lat_id_inst", id_inst, 32'h0000_0013);
    tick();
    chk("lat_drained", {31'd0, id_valid}, 32'd0);
`else
    // Bypass: consumed in the same cycle when decode is ready.
    if_valid = 1'b1; if_pc = 32'h200; if_inst = 32'h13;
    #1;
    chk("byp_id_valid", {31'd0, id_valid}, 32'd1);
    chk("byp_id_pc", id_pc, 32'h200);
    tick();
    if_valid = 1'b0;
    #1;
    chk("byp_not_stored", {31'd0, id_valid}, 32'd0);
    // Bypass with decode stalled: entry is written and presented again next cycle.
    stall_id = 1'b1; if_valid = 1'b1; if_pc = 32'h204; if_inst = 32'h33;
    #1;
    chk("byp_stall_id_pc", id_pc, 32'h204);
    tick();
    if_valid = 1'b0; stall_id = 1'b0;
    #1;
    chk("byp_retained_valid", {31'd0, id_valid}, 32'd1);
    chk("byp_retained_pc", id_pc, 32'h204);
    tick();
    chk("byp_drained", {31'd0, id_valid}, 32'd0);
`endif

    // Fill to full under decode stall; fifth push must be held off.
    stall_id = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_stall_if_low", {31'd0, stall_if}, 32'd0);
      push_one(32'h100 + 32'(4 * i), 32'(i + 1));
    end
    chk("full_stall_if", {31'd0, stall_if}, 32'd1);
    chk("full_head_pc", id_pc, 32'h100);
    if_valid = 1'b1; if_pc = 32'h110; if_inst = 32'd5;
    tick();
    tick();
    chk("full_held_stall_if", {31'd0, stall_if}, 32'd1);
    chk("full_held_head_pc", id_pc, 32'h100);
    chk("full_held_head_inst", id_inst, 32'd1);
    stall_id = 1'b0;
    exp_pc = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("drain_valid", {31'd0, id_valid}, 32'd1);
      chk("drain_pc", id_pc, exp_pc[k]);
      chk("drain_inst", id_inst, 32'(k + 1));
      accepted = if_valid && !stall_if;
      tick();
      if (accepted) if_valid = 1'b0;
    end
    chk("drain_empty", {31'd0, id_valid}, 32'd0);

    // Three queued, then simultaneous push/pop across the pointer wrap.
    stall_id = 1'b1;
    for (int i = 0; i < 3; i++) push_one(32'h300 + 32'(4 * i), 32'h0);
    stall_id = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if_valid = 1'b1; if_pc = 32'h30C + 32'(4 * k); if_inst = 32'h0;
      #1;
      chk("stream_pc", id_pc, 32'h300 + 32'(4 * k));
      chk("stream_stall_if", {31'd0, stall_if}, 32'd0);
      tick();
    end
    if_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stream_tail_pc", id_pc, 32'h318 + 32'(4 * k));
      tick();
    end
    chk("stream_empty", {31'd0, id_valid}, 32'd0);

    // Flush with a concurrent push.
    stall_id = 1'b1;
    for (int i = 0; i < 3; i++) push_one(32'h400 + 32'(4 * i), 32'h77);
    flush = 1'b1; if_valid = 1'b1; if_pc = 32'h40C; if_inst = 32'h99;
    #1;
    chk("flush_id_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_id_pc", id_pc, 32'd0);
    tick();
    flush = 1'b0; if_valid = 1'b0;
    #1;
    chk("post_flush_valid", {31'd0, id_valid}, 32'd0);
    chk("post_flush_inst", id_inst, 32'd0);
    chk("post_flush_stall_if", {31'd0, stall_if}, 32'd0);

    // Reset dominates flush and push on a full queue.
    for (int i = 0; i < 4; i++) push_one(32'h500 + 32'(4 * i), 32'h55);
    chk("refill_full", {31'd0, stall_if}, 32'd1);
    rst = 1'b1; flush = 1'b1; if_valid = 1'b1; if_pc = 32'h5AA;
    tick();
    rst = 1'b0; flush = 1'b0; if_valid = 1'b0;
    #1;
    chk("rst_full_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_full_pc", id_pc, 32'd0);
    chk("rst_full_stall_if", {31'd0, stall_if}, 32'd0);
    push_one(32'h600, 32'h66);
    #1;
    chk("after_rst_push_pc", id_pc, 32'h600);
    chk("after_rst_push_inst", id_inst, 32'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 Parameter DEPTH, 4, number of queue entries; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 flush  input  1  exception/redirect flush from the pipeline controller.
REQ-005 if_valid  input  1  fetch side presents a fetched instruction this cycle.
REQ-006 if_pc  input  `ADDR_BUS  address of the presented instruction.
REQ-007 if_inst  input  `DATA_BUS  instruction word read from ROM.
REQ-008 stall_if  output  1  queue full; OR-ed into the PC stage stall.
REQ-009 stall_id  input  1  decode stage cannot accept an instruction this cycle.
REQ-010 id_valid  output  1  head entry presented to decode.
REQ-011 id_pc  output  `ADDR_BUS  head entry address.
REQ-012 id_inst  output  `DATA_BUS  head entry instruction word.

Function
REQ-013 Storage: DEPTH entries of {pc, inst}; read/write pointers of log2(DEPTH)+1 bits, MSB as wrap bit; empty = pointers equal; full = low bits equal, MSBs differ.
REQ-014 Push SHALL occur when if_valid && !full && !flush; entry written at write pointer, pointer +1 next edge.
REQ-015 Pop SHALL occur when id_valid && !stall_id && !flush; read pointer +1 next edge.
REQ-016 Push and pop in the same cycle SHALL both take effect; occupancy unchanged.
REQ-017 full is from registered pointers: push while full is dropped even if a pop occurs that cycle; fetch side MUST hold if_valid/if_pc/if_inst while stall_if=1.
REQ-018 stall_if = full, combinational from registered state.
REQ-019 id_valid = !empty && !flush; id_pc/id_inst = head entry when id_valid=1, else 0 (id_inst 0 decodes as NOP).
REQ-020 Default latency: instruction pushed in cycle N SHALL be visible at id_* in cycle N+1 at earliest.
REQ-021 Pointer wrap: DEPTH-1 to 0 SHALL toggle MSB; order SHALL be strictly FIFO across wrap.
REQ-022 flush SHALL set both pointers to 0 at next edge, discarding all entries and any same-cycle push/pop.
REQ-023 id_* held stable while id_valid=1 and stall_id=1.

Reset
REQ-024 rst SHALL set both pointers to 0; outputs next cycle: id_valid=0, id_pc=0, id_inst=0, stall_if=0.
REQ-025 rst SHALL dominate flush, push and pop in the same cycle; entry storage need not be reset.
REQ-026 rst asserted mid-operation with entries queued SHALL discard them identically to power-on reset.

Configuration
REQ-027 Macro INST_QUEUE_BYPASS_EN: when defined, empty && if_valid && !flush SHALL drive id_valid=1, id_pc=if_pc, id_inst=if_inst combinationally (0-cycle latency).
REQ-028 With bypass active: stall_id=0 -> instruction consumed, not written, pointers unchanged; stall_id=1 -> written normally per REQ-014.
REQ-029 Macro undefined: no if_* to id_* combinational path; REQ-020 latency applies.

Verification
REQ-030 Reset then if_valid=1, if_pc=0x80000000, if_inst=0x00000013, stall_id=0 -> next cycle id_valid=1, id_pc=0x80000000, id_inst=0x00000013; following cycle id_valid=0 (bypass off).
REQ-031 stall_id=1, push 4 entries pc=0x100,0x104,0x108,0x10C -> stall_if=1 after 4th; 5th push (0x110) held; release stall_id -> pops 0x100..0x110 in order.
REQ-032 Fill 3, then 6 cycles simultaneous push/pop -> occupancy stays 3, pc order continuous across pointer wrap, stall_if never 1.
REQ-033 3 entries queued, flush=1 with if_valid=1 -> id_valid=0 that cycle; next cycle empty, id_inst=0, push of that cycle absent.
REQ-034 Full queue with rst=1 and flush=1 same cycle -> next cycle id_valid=0, id_pc=0, stall_if=0.
REQ-035 INST_QUEUE_BYPASS_EN defined, empty, if_valid=1, if_pc=0x200, stall_id=0 -> same-cycle id_valid=1, id_pc=0x200; next cycle empty; repeat with stall_id=1 -> entry retained and presented next cycle.
